// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, self-test vector record, BIST FSM states.
// No ports; imported by the BIST driver and its vector ROM.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 5;
  localparam int unsigned DATA_W     = 32;

  // ALU operation select codes
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_NOR   = 5'd5,
    ALU_SLL   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_NAND  = 5'd11,
    ALU_XNOR  = 5'd12,
    ALU_ANDN  = 5'd13,
    ALU_ORN   = 5'd14,
    ALU_MUL   = 5'd15,
    ALU_PASSA = 5'd16
  } alu_op_t;

  // One self-test vector: stimulus plus expected ALU response
  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     exp_result;
    logic                  exp_zero;
  } alu_vec_t;

  // BIST sequencer states
  typedef enum logic [2:0] {
    BIST_IDLE   = 3'd0,
    BIST_LOAD   = 3'd1,
    BIST_SETTLE = 3'd2,
    BIST_CHECK  = 3'd3,
    BIST_DONE   = 3'd4
  } bist_state_t;

  // Build a vector record from its fields
  function automatic alu_vec_t mk_vec(input alu_op_t          op,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic [DATA_W-1:0] exp_result,
                                      input logic              exp_zero);
    alu_vec_t v;
    v.ctrl       = ALU_CTRL_W'(op);
    v.a          = a;
    v.b          = b;
    v.exp_result = exp_result;
    v.exp_zero   = exp_zero;
    return v;
  endfunction

endpackage

// File: rtl/alu_bist_vector_rom.sv
// Combinational self-test vector table for the ALU BIST driver.
// Ports:
//   idx   - vector index
//   vec_c - vector record at idx (all zero for indices past the table)
module alu_bist_vector_rom
  import alu_pkg::*;
#(
  parameter int unsigned IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  output alu_vec_t         vec_c
);

  // Index -> vector lookup; entry 2 is the only subtract vector
  always_comb begin
    vec_c = '0;
    case (32'(idx))
      32'd0:  vec_c = mk_vec(ALU_ADD,   32'd15,        32'd15,        32'd30,        1'b0);
      32'd1:  vec_c = mk_vec(ALU_ADD,   32'd65,        32'd33,        32'd98,        1'b0);
      32'd2:  vec_c = mk_vec(ALU_SUB,   32'd100,       32'd100,       32'd0,         1'b1);
      32'd3:  vec_c = mk_vec(ALU_ANDN,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000, 1'b0);
      32'd4:  vec_c = mk_vec(ALU_AND,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1);
      32'd5:  vec_c = mk_vec(ALU_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0);
      32'd6:  vec_c = mk_vec(ALU_XOR,   32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
      32'd7:  vec_c = mk_vec(ALU_NOR,   32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
      32'd8:  vec_c = mk_vec(ALU_SLL,   32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0);
      32'd9:  vec_c = mk_vec(ALU_SRL,   32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0);
      32'd10: vec_c = mk_vec(ALU_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
      32'd11: vec_c = mk_vec(ALU_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
      32'd12: vec_c = mk_vec(ALU_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1);
      32'd13: vec_c = mk_vec(ALU_NAND,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      32'd14: vec_c = mk_vec(ALU_XNOR,  32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0);
      32'd15: vec_c = mk_vec(ALU_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
      32'd16: vec_c = mk_vec(ALU_PASSA, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
      default: vec_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist_driver.sv
// Sequential self-test initiator for the 32-bit ALU datapath. Walks the vector
// ROM, drives each vector into the ALU, waits SETTLE_CYCLES, then compares the
// ALU response and tallies failures.
// Ports:
//   Clk, Reset     - clock (rising edge), synchronous active-high reset
//   Start          - one-cycle pulse, starts a run from IDLE or DONE
//   ALUControl/A/B - operation and operands driven to the ALU
//   ALUResult/Zero - ALU response
//   Busy/Done/Pass - run status; Pass valid while Done
//   FailCount      - mismatching vectors in the last run (saturating)
//   FirstFailValid/FirstFailIdx - first mismatching vector of the run
module alu_bist_driver
  import alu_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 17,
  parameter int unsigned IDX_W         = 5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic                  Zero,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pass,
  output logic [IDX_W:0]        FailCount,
  output logic                  FirstFailValid,
  output logic [IDX_W-1:0]      FirstFailIdx
);

  localparam int unsigned FAIL_W = IDX_W + 1;
  localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = {FAIL_W{1'b1}};
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  bist_state_t           state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [ALU_CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0]     a_d, b_d;
  logic [FAIL_W-1:0]     fail_d;
  logic                  ffv_d;
  logic [IDX_W-1:0]      ffi_d;
  logic                  busy_d, done_d, pass_d;
  alu_vec_t              vec_c;
  logic                  mismatch_c;

  alu_bist_vector_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .idx   (idx),
    .vec_c (vec_c)
  );

  // Result and flag are judged independently; any difference fails the vector
  assign mismatch_c = (ALUResult != vec_c.exp_result) || (Zero != vec_c.exp_zero);

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= BIST_IDLE;
      idx            <= '0;
      cnt            <= '0;
      ALUControl     <= '0;
      A              <= '0;
      B              <= '0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Pass           <= 1'b0;
      FailCount      <= '0;
      FirstFailValid <= 1'b0;
      FirstFailIdx   <= '0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      cnt            <= cnt_d;
      ALUControl     <= ctrl_d;
      A              <= a_d;
      B              <= b_d;
      Busy           <= busy_d;
      Done           <= done_d;
      Pass           <= pass_d;
      FailCount      <= fail_d;
      FirstFailValid <= ffv_d;
      FirstFailIdx   <= ffi_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    ctrl_d  = ALUControl;
    a_d     = A;
    b_d     = B;
    fail_d  = FailCount;
    ffv_d   = FirstFailValid;
    ffi_d   = FirstFailIdx;
    done_d  = 1'b0;
    pass_d  = 1'b0;

    case (state)
      BIST_IDLE: begin
        if (Start) begin
          state_d = BIST_LOAD;
          idx_d   = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end
      end

      BIST_LOAD: begin
        ctrl_d  = vec_c.ctrl;
        a_d     = vec_c.a;
        b_d     = vec_c.b;
        cnt_d   = SETTLE_LD;
        state_d = BIST_SETTLE;
      end

      BIST_SETTLE: begin
        if (cnt == '0) begin
          state_d = BIST_CHECK;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      BIST_CHECK: begin
        if (mismatch_c) begin
          if (FailCount != FAIL_MAX) begin
            fail_d = FailCount + FAIL_W'(1);
          end
          if (!FirstFailValid) begin
            ffv_d = 1'b1;
            ffi_d = idx;
          end
        end
        if (idx == LAST_IDX) begin
          state_d = BIST_DONE;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = BIST_LOAD;
        end
      end

      BIST_DONE: begin
        // Operands keep the last vector; a Start begins a fresh run
        if (Start) begin
          state_d = BIST_LOAD;
          idx_d   = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
        end else begin
          done_d = 1'b1;
          pass_d = (FailCount == '0);
        end
      end

      default: state_d = BIST_IDLE;
    endcase

    busy_d = (state_d == BIST_LOAD) || (state_d == BIST_SETTLE) || (state_d == BIST_CHECK);
  end

endmodule

// File: tb/tb_alu_bist_driver.sv
// Self-checking bench for alu_bist_driver: a behavioural ALU with selectable
// fault injection answers the driver; expected tallies come from a vector list
// evaluated against the clean and faulty ALU behaviour.
module tb_alu_bist_driver;

  localparam int NV  = 17;
  localparam int PER = 3;   // cycles per vector with SETTLE_CYCLES=1
  localparam int PER3 = 5;  // cycles per vector with SETTLE_CYCLES=3

  logic        Clk = 1'b0;
  logic        Reset, Start, reset3, start3;

  logic [4:0]  ctrl1, ctrl3;
  logic [31:0] a1, b1, res1, a3, b3, res3;
  logic        z1, z3;
  logic        busy1, done1, pass1, ffv1;
  logic        busy3, done3, pass3, ffv3;
  logic [5:0]  fc1, fc3;
  logic [4:0]  ffi1, ffi3;

  int          fmode = 0;
  logic [4:0]  fop = 5'd0;

  int total = 0;
  int bad   = 0;

  logic [4:0]  t_op [NV];
  logic [31:0] t_a  [NV];
  logic [31:0] t_b  [NV];

  always #5 Clk = ~Clk;

  alu_bist_driver #(.NUM_VECTORS(17), .IDX_W(5), .SETTLE_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .ALUControl(ctrl1), .A(a1), .B(b1), .ALUResult(res1), .Zero(z1),
    .Busy(busy1), .Done(done1), .Pass(pass1), .FailCount(fc1),
    .FirstFailValid(ffv1), .FirstFailIdx(ffi1)
  );

  alu_bist_driver #(.NUM_VECTORS(17), .IDX_W(5), .SETTLE_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset(reset3), .Start(start3),
    .ALUControl(ctrl3), .A(a3), .B(b3), .ALUResult(res3), .Zero(z3),
    .Busy(busy3), .Done(done3), .Pass(pass3), .FailCount(fc3),
    .FirstFailValid(ffv3), .FirstFailIdx(ffi3)
  );

  // Behavioural ALU; mode 1: result+1 on op fo, 2: Zero forced 1, 3: Zero inverted on op fo
  function automatic logic [32:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int mode,
                                            input logic [4:0] fo);
    logic [31:0] r;
    logic        z;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = ~(a | b);
      5'd6:  r = a << b[4:0];
      5'd7:  r = a >> b[4:0];
      5'd8:  r = $signed(a) >>> b[4:0];
      5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10: r = (a < b) ? 32'd1 : 32'd0;
      5'd11: r = ~(a & b);
      5'd12: r = ~(a ^ b);
      5'd13: r = a & ~b;
      5'd14: r = a | ~b;
      5'd15: r = a * b;
      5'd16: r = a;
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
    case (mode)
      1: if (op == fo) r = r + 32'd1;
      2: z = 1'b1;
      3: if (op == fo) z = ~z;
      default: ;
    endcase
    return {z, r};
  endfunction

  always_comb {z1, res1} = alu_model(ctrl1, a1, b1, fmode, fop);
  always_comb {z3, res3} = alu_model(ctrl3, a3, b3, 0, 5'd0);

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_status"}, {busy1, done1, pass1, fc1, ffv1, ffi1}, 96'd0);
    check_eq({tag, "_operands"}, {ctrl1, a1, b1}, 96'd0);
  endtask

  // One run of the main instance; stray Start at stray_at, Reset at reset_at (-1 = none)
  task automatic run_main(input int mode, input logic [4:0] op, input int stray_at,
                          input int reset_at, output bit aborted);
    int ef, efirst, n, v;
    bit efv;
    ef = 0; efirst = 0; efv = 0;
    for (int i = 0; i < NV; i++) begin
      if (alu_model(t_op[i], t_a[i], t_b[i], mode, op) !== alu_model(t_op[i], t_a[i], t_b[i], 0, 5'd0)) begin
        ef++;
        if (!efv) begin efv = 1; efirst = i; end
      end
    end
    fmode = mode; fop = op;
    aborted = 0;
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    n = 0;
    check_eq("start_status", {busy1, done1, fc1, ffv1}, {1'b1, 1'b0, 6'd0, 1'b0});
    while (!done1 && n < 200) begin
      if (n == reset_at) begin
        aborted = 1;
        break;
      end
      if (n >= 1 && (n - 1) / PER < NV) begin
        v = (n - 1) / PER;
        check_eq("operands", {ctrl1, a1, b1}, {t_op[v], t_a[v], t_b[v]});
      end
      Start = (n == stray_at);
      @(negedge Clk);
      n++;
    end
    Start = 1'b0;
    if (aborted) begin
      Reset = 1'b1;
      @(negedge Clk);
      check_reset_vals("midrun_reset");
      Reset = 1'b0;
    end else begin
      check_eq("done_latency", 96'(n), 96'(NV * PER + 1));
      check_eq("pass", 96'(pass1), 96'(ef == 0));
      check_eq("fail_count", 96'(fc1), 96'(ef));
      check_eq("first_fail_valid", 96'(ffv1), 96'(efv));
      check_eq("first_fail_idx", 96'(ffi1), 96'(efirst));
      check_eq("busy_at_done", 96'(busy1), 96'd0);
      @(negedge Clk);
      check_eq("done_hold", {done1, busy1}, {1'b1, 1'b0});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    int n, v, mode, stray, rst;
    logic [4:0] op;

    t_op[0]  = 5'd0;  t_a[0]  = 32'd15;        t_b[0]  = 32'd15;
    t_op[1]  = 5'd0;  t_a[1]  = 32'd65;        t_b[1]  = 32'd33;
    t_op[2]  = 5'd1;  t_a[2]  = 32'd100;       t_b[2]  = 32'd100;
    t_op[3]  = 5'd13; t_a[3]  = 32'hFF00_FF00; t_b[3]  = 32'h0F0F_0F0F;
    t_op[4]  = 5'd2;  t_a[4]  = 32'hF0F0_F0F0; t_b[4]  = 32'h0F0F_0F0F;
    t_op[5]  = 5'd3;  t_a[5]  = 32'h1234_0000; t_b[5]  = 32'h0000_5678;
    t_op[6]  = 5'd4;  t_a[6]  = 32'hAAAA_AAAA; t_b[6]  = 32'hFFFF_FFFF;
    t_op[7]  = 5'd5;  t_a[7]  = 32'h0;         t_b[7]  = 32'h0;
    t_op[8]  = 5'd6;  t_a[8]  = 32'h1;         t_b[8]  = 32'd31;
    t_op[9]  = 5'd7;  t_a[9]  = 32'h8000_0000; t_b[9]  = 32'd31;
    t_op[10] = 5'd8;  t_a[10] = 32'h8000_0000; t_b[10] = 32'd4;
    t_op[11] = 5'd9;  t_a[11] = 32'hFFFF_FFFF; t_b[11] = 32'd1;
    t_op[12] = 5'd10; t_a[12] = 32'hFFFF_FFFF; t_b[12] = 32'd1;
    t_op[13] = 5'd11; t_a[13] = 32'hFFFF_FFFF; t_b[13] = 32'hFFFF_FFFF;
    t_op[14] = 5'd12; t_a[14] = 32'h0000_FFFF; t_b[14] = 32'h0000_FFFF;
    t_op[15] = 5'd15; t_a[15] = 32'h0001_0000; t_b[15] = 32'h0001_0000;
    t_op[16] = 5'd16; t_a[16] = 32'hDEAD_BEEF; t_b[16] = 32'h0;

    Reset = 1'b1; reset3 = 1'b1; Start = 1'b0; start3 = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_vals("reset");
    check_eq("reset3", {busy3, done3, pass3, fc3, ffv3, ffi3}, 96'd0);
    Reset = 1'b0; reset3 = 1'b0;
    @(negedge Clk);

    // Clean run with an ignored Start at cycle 10
    run_main(0, 5'd0, 10, -1, ab);
    // Result fault on SUB only
    run_main(1, 5'd1, -1, -1, ab);
    // Re-run from DONE with a clean ALU clears the previous tallies
    run_main(0, 5'd0, -1, -1, ab);
    // Zero flag stuck at 1
    run_main(2, 5'd0, -1, -1, ab);
    // Reset at cycle 20, then a normal run
    run_main(0, 5'd0, -1, 20, ab);
    run_main(0, 5'd0, -1, -1, ab);

    // Randomized fault modes, stray Starts and mid-run resets
    for (int k = 0; k < 8; k++) begin
      mode  = int'($urandom_range(0, 3));
      op    = 5'($urandom_range(0, 16));
      stray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 45)) : -1;
      rst   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 48)) : -1;
      run_main(mode, op, stray, rst, ab);
      if (ab) run_main(0, 5'd0, -1, -1, ab);
    end

    // Three-cycle settle instance: operands held through each compare
    @(negedge Clk) start3 = 1'b1;
    @(negedge Clk) start3 = 1'b0;
    n = 0;
    while (!done3 && n < 400) begin
      if (n >= 1 && (n - 1) / PER3 < NV) begin
        v = (n - 1) / PER3;
        check_eq("operands3", {ctrl3, a3, b3}, {t_op[v], t_a[v], t_b[v]});
      end
      @(negedge Clk);
      n++;
    end
    check_eq("done_latency3", 96'(n), 96'(NV * PER3 + 1));
    check_eq("result3", {pass3, fc3, ffv3}, {1'b1, 6'd0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
